// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcode/funct
// constants, ALU operation codes and datapath mux-select codes.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_MEM   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_EXEC_I   = 4'd10,
    S_WB_I     = 4'd11,
    S_JR       = 4'd12,
    S_JAL      = 4'd13,
    S_ILLEGAL  = 4'd14,
    S_UNDEF    = 4'd15
  } state_t;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;
  localparam logic [5:0] FUNC_JR   = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic       SRC_A_PC  = 1'b0;
  localparam logic       SRC_A_REG = 1'b1;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

endpackage

// File: rtl/mc_alu_decode.sv
// R-type funct to ALU operation decode; valid flags the supported arithmetic
// functs so DECODE can route everything else to ILLEGAL.
module mc_alu_decode
  import mips_mc_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] alu_operation,
  output logic       valid
);

  always_comb begin
    alu_operation = ALU_ADD;
    valid         = 1'b1;
    case (func)
      FUNC_ADD: alu_operation = ALU_ADD;
      FUNC_SUB: alu_operation = ALU_SUB;
      FUNC_AND: alu_operation = ALU_AND;
      FUNC_OR:  alu_operation = ALU_OR;
      FUNC_SLT: alu_operation = ALU_SLT;
      default:  valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multi-cycle MIPS datapath with a shared memory.
// state    | meaning
// FETCH    | read instr, IR <= mem[PC], PC <= PC+4
// DECODE   | ALUOut <= branch target, dispatch on opc
// MEM_ADDR | ALUOut <= A + sext(imm)
// MEM_RD   | MDR <= mem[ALUOut]
// WB_MEM   | rt <= MDR
// MEM_WR   | mem[ALUOut] <= B
// EXEC_R   | ALUOut <= A op B
// WB_R     | rd <= ALUOut
// BRANCH   | PC <= ALUOut if A == B
// JUMP     | PC <= jump target
// EXEC_I   | ALUOut <= A op sext(imm)
// WB_I     | rt <= ALUOut
// JR       | PC <= A
// JAL      | $31 <= PC, PC <= jump target
// ILLEGAL  | unsupported instruction
module multicycle_controller
  import mips_mc_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_operation,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [2:0] r_alu_op;
  logic       r_func_valid;

  // The branch decision is taken by the datapath (pc_write_cond & zero).
  logic unused_zero;
  assign unused_zero = zero;

  mc_alu_decode u_alu_decode (
    .func          (func),
    .alu_operation (r_alu_op),
    .valid         (r_func_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = REG_DST_RT;
    mem_to_reg    = M2R_ALUOUT;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_REG;
    alu_operation = ALU_ADD;
    pc_src        = PC_SRC_ALU;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_ALU;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRC_B_IMM_SH;
        case (opc)
          OPC_RTYPE: begin
            if (func == FUNC_JR)   state_d = S_JR;
            else if (r_func_valid) state_d = S_EXEC_R;
            else                   state_d = S_ILLEGAL;
          end
          OPC_LW, OPC_SW:       state_d = S_MEM_ADDR;
          OPC_BEQ:              state_d = S_BRANCH;
          OPC_ADDI, OPC_SLTI:   state_d = S_EXEC_I;
          OPC_J:                state_d = S_JUMP;
          OPC_JAL:              state_d = S_JAL;
          default:              state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        state_d   = (opc == OPC_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        state_d  = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        reg_dst    = REG_DST_RT;
        mem_to_reg = M2R_MDR;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a     = SRC_A_REG;
        alu_src_b     = SRC_B_REG;
        alu_operation = r_alu_op;
        state_d       = S_WB_R;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = REG_DST_RD;
        mem_to_reg = M2R_ALUOUT;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = SRC_A_REG;
        alu_src_b     = SRC_B_REG;
        alu_operation = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_SRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PC_SRC_JUMP;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a     = SRC_A_REG;
        alu_src_b     = SRC_B_IMM;
        alu_operation = (opc == OPC_SLTI) ? ALU_SLT : ALU_ADD;
        state_d       = S_WB_I;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        reg_dst    = REG_DST_RT;
        mem_to_reg = M2R_ALUOUT;
        instr_done = 1'b1;
      end
      S_JR: begin
        pc_write   = 1'b1;
        pc_src     = PC_SRC_REG;
        instr_done = 1'b1;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        reg_dst    = REG_DST_RA;
        mem_to_reg = M2R_PC;
        pc_write   = 1'b1;
        pc_src     = PC_SRC_JUMP;
        instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        if (HALT_ON_ILLEGAL) begin
          state_d = S_ILLEGAL;
        end else begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Reset masks the FETCH decode so nothing is issued while rst is held.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = REG_DST_RT;
      mem_to_reg    = M2R_ALUOUT;
      alu_src_a     = SRC_A_PC;
      alu_src_b     = SRC_B_REG;
      alu_operation = ALU_ADD;
      pc_src        = PC_SRC_ALU;
      instr_done    = 1'b0;
      illegal       = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed and random instructions compared cycle by cycle
// against per-instruction control-word sequences derived from the ISA behaviour.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opc = '0;
  logic [5:0] func = '0;
  logic       zero = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_write, alu_src_a, instr_done, illegal;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic [2:0] alu_operation;

  int   n_checks = 0;
  int   n_pass   = 0;
  ctl_t exp_q[$];
  ctl_t obs;

  always #5 clk = ~clk;

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .opc           (opc),
    .func          (func),
    .zero          (zero),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_operation (alu_operation),
    .pc_src        (pc_src),
    .instr_done    (instr_done),
    .illegal       (illegal)
  );

  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                alu_operation, pc_src, instr_done, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic ctl_t idle();
    ctl_t c = '0;
    c.alu_op = 3'b010;
    return c;
  endfunction

  // Returns 1 and the ALU op for the five supported R-type functs.
  function automatic bit r_op(input logic [5:0] f, output logic [2:0] op);
    op = 3'b010;
    case (f)
      6'b100000: op = 3'b010;
      6'b100010: op = 3'b110;
      6'b100100: op = 3'b000;
      6'b100101: op = 3'b001;
      6'b101010: op = 3'b111;
      default:   return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic bit legal(input logic [5:0] o, input logic [5:0] f);
    logic [2:0] op;
    if (o == 6'b000000) return (f == 6'b001000) || r_op(f, op);
    return o inside {6'b100011, 6'b101011, 6'b000100, 6'b001000,
                     6'b001010, 6'b000010, 6'b000011};
  endfunction

  // Expected control words, one per cycle, for instruction (o, f).
  task automatic build(input logic [5:0] o, input logic [5:0] f);
    ctl_t       c;
    logic [2:0] op;
    exp_q.delete();
    c = idle(); c.mem_read = 1; c.ir_write = 1; c.alu_src_b = 2'b01; c.pc_write = 1;
    exp_q.push_back(c);
    c = idle(); c.alu_src_b = 2'b11;
    exp_q.push_back(c);
    if (!legal(o, f)) begin
      c = idle(); c.illegal = 1;
      repeat (10) exp_q.push_back(c);
    end else if (o == 6'b100011 || o == 6'b101011) begin
      c = idle(); c.alu_src_a = 1; c.alu_src_b = 2'b10;
      exp_q.push_back(c);
      if (o == 6'b100011) begin
        c = idle(); c.iord = 1; c.mem_read = 1;
        exp_q.push_back(c);
        c = idle(); c.reg_write = 1; c.mem_to_reg = 2'b01; c.instr_done = 1;
        exp_q.push_back(c);
      end else begin
        c = idle(); c.iord = 1; c.mem_write = 1; c.instr_done = 1;
        exp_q.push_back(c);
      end
    end else if (o == 6'b000000 && f == 6'b001000) begin
      c = idle(); c.pc_write = 1; c.pc_src = 2'b11; c.instr_done = 1;
      exp_q.push_back(c);
    end else if (o == 6'b000000) begin
      void'(r_op(f, op));
      c = idle(); c.alu_src_a = 1; c.alu_op = op;
      exp_q.push_back(c);
      c = idle(); c.reg_write = 1; c.reg_dst = 2'b01; c.instr_done = 1;
      exp_q.push_back(c);
    end else if (o == 6'b000100) begin
      c = idle(); c.alu_src_a = 1; c.alu_op = 3'b110; c.pc_write_cond = 1;
      c.pc_src = 2'b01; c.instr_done = 1;
      exp_q.push_back(c);
    end else if (o == 6'b001000 || o == 6'b001010) begin
      c = idle(); c.alu_src_a = 1; c.alu_src_b = 2'b10;
      c.alu_op = (o == 6'b001010) ? 3'b111 : 3'b010;
      exp_q.push_back(c);
      c = idle(); c.reg_write = 1; c.instr_done = 1;
      exp_q.push_back(c);
    end else if (o == 6'b000010) begin
      c = idle(); c.pc_write = 1; c.pc_src = 2'b10; c.instr_done = 1;
      exp_q.push_back(c);
    end else begin
      c = idle(); c.reg_write = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
      c.pc_write = 1; c.pc_src = 2'b10; c.instr_done = 1;
      exp_q.push_back(c);
    end
  endtask

  // Runs one instruction from its FETCH cycle; stops early after cycle abort_at.
  task automatic run(input string name, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input int abort_at);
    bit exp_load;
    opc = o; func = f; zero = z;
    build(o, f);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      check($sformatf("%s op=%b fn=%b c%0d", name, o, f, k + 1), obs, exp_q[k]);
      if (exp_q[k].pc_write_cond) begin
        exp_load = z;
        check($sformatf("%s pc_load z=%0b", name, z),
              pc_write | (pc_write_cond & zero), exp_load);
      end
      if (k == abort_at) return;
    end
  endtask

  // Asynchronous reset pulse starting mid-cycle; released just after an edge.
  task automatic pulse_reset(input string name);
    #1 rst = 1'b1;
    #1 check({name, " async"}, obs, idle());
    @(posedge clk);
    #1 check({name, " held"}, obs, idle());
    rst = 1'b0;
  endtask

  logic [5:0] legal_opc[8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                               6'b001000, 6'b001010, 6'b000010, 6'b000011};
  logic [5:0] r_funcs[6]   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b101010, 6'b001000};

  initial begin
    logic [5:0] o, f;
    #2 check("reset idle", obs, idle());
    @(posedge clk);
    #1 rst = 1'b0;

    run("lw",      6'b100011, 6'b000000, 1'b0, -1);
    run("add",     6'b000000, 6'b100000, 1'b0, -1);
    run("sub",     6'b000000, 6'b100010, 1'b1, -1);
    run("beq z1",  6'b000100, 6'b000000, 1'b1, -1);
    run("beq z0",  6'b000100, 6'b000000, 1'b0, -1);
    run("jal",     6'b000011, 6'b000000, 1'b0, -1);
    run("jr",      6'b000000, 6'b001000, 1'b0, -1);
    run("sw",      6'b101011, 6'b000000, 1'b0, -1);
    run("slti",    6'b001010, 6'b000000, 1'b0, -1);
    run("lw abort", 6'b100011, 6'b000000, 1'b0, 3);
    pulse_reset("rst in MEM_RD");
    run("after rst", 6'b000010, 6'b000000, 1'b0, -1);
    run("illegal", 6'b111111, 6'b000000, 1'b0, -1);
    pulse_reset("rst in ILLEGAL");
    run("bad funct", 6'b000000, 6'b000111, 1'b0, -1);
    pulse_reset("rst bad funct");

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        o = 6'($urandom_range(0, 63));
        f = 6'($urandom_range(0, 63));
        if (legal(o, f)) o = 6'b111110;
      end else begin
        o = legal_opc[$urandom_range(0, 7)];
        f = (o == 6'b000000) ? r_funcs[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
      end
      run("rand", o, f, 1'($urandom_range(0, 1)), -1);
      if (!legal(o, f)) pulse_reset("rand rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
